// File: rtl/sap_ram_pkg.sv
// Shared types and default timing for the SAP RAM sequencer.
package sap_ram_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_PULSE  = 3'd2,
        W_HOLD   = 3'd3,
        R_ACCESS = 3'd4,
        DONE     = 3'd5
    } ram_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } ram_owner_t;

    localparam int RAM_SETUP_CYC  = 1;
    localparam int RAM_PULSE_CYC  = 2;
    localparam int RAM_HOLD_CYC   = 1;
    localparam int RAM_ACCESS_CYC = 2;

endpackage

// File: rtl/sap_ram_arb.sv
// Fixed-priority two-requester grant; the loader wins ties, and nothing is
// granted while the sequencer is mid-transaction.
module sap_ram_arb
    import sap_ram_pkg::*;
(
    input  logic       lock,
    input  logic       ld_req,
    input  logic       cpu_req,
    output logic       gnt,
    output ram_owner_t gnt_own
);

    // Grant and owner select
    always_comb begin
        gnt     = !lock && (ld_req || cpu_req);
        gnt_own = ld_req ? OWN_LD : OWN_CPU;
    end

endmodule

// File: rtl/sap_ram_seq.sv
// Sequencer for a 16x8 store built from two 189-type 16x4 RAMs.
// Every output is a flop; output flops are loaded from the next state so the
// chip pins change on the same edge as the state they belong to.
module sap_ram_seq
    import sap_ram_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = RAM_SETUP_CYC,
    parameter int PULSE_CYC  = RAM_PULSE_CYC,
    parameter int HOLD_CYC   = RAM_HOLD_CYC,
    parameter int ACCESS_CYC = RAM_ACCESS_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_cs,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_o,
    output logic              busy
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || ACCESS_CYC < 1) begin : g_bad_param
        $error("sap_ram_seq: all timing parameters must be >= 1");
    end

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HA  = (HOLD_CYC > ACCESS_CYC) ? HOLD_CYC : ACCESS_CYC;
    localparam int MAX_CYC = (MAX_SP > MAX_HA) ? MAX_SP : MAX_HA;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    ram_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ram_owner_t        own_q, own_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              ram_cs_q, ram_cs_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ld_ack_q, ld_ack_d;

    logic              gnt;
    ram_owner_t        gnt_own;

    sap_ram_arb u_arb (
        .lock    (state_q != IDLE),
        .ld_req  (ld_req),
        .cpu_req (cpu_req),
        .gnt     (gnt),
        .gnt_own (gnt_own)
    );

    // Remaining-cycle count loaded on entry to a timed state (length - 1)
    function automatic logic [CNT_W-1:0] phase_len(input ram_state_t s);
        case (s)
            W_SETUP:  phase_len = CNT_W'(SETUP_CYC - 1);
            W_PULSE:  phase_len = CNT_W'(PULSE_CYC - 1);
            W_HOLD:   phase_len = CNT_W'(HOLD_CYC - 1);
            R_ACCESS: phase_len = CNT_W'(ACCESS_CYC - 1);
            default:  phase_len = '0;
        endcase
    endfunction

    // Next state, phase counter, request latch and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_d       = own_q;
        wr_d        = wr_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt) begin
                    own_d = gnt_own;
                    if (gnt_own == OWN_LD) begin
                        wr_d    = 1'b1;
                        ram_a_d = ld_addr;
                        ram_d_d = ld_wdata;
                    end else begin
                        wr_d    = cpu_wr;
                        ram_a_d = cpu_addr;
                        ram_d_d = cpu_wdata;
                    end
                    state_d = wr_d ? W_SETUP : R_ACCESS;
                end
            end
            W_SETUP:  if (cnt_q == '0) state_d = W_PULSE;
            W_PULSE:  if (cnt_q == '0) state_d = W_HOLD;
            W_HOLD:   if (cnt_q == '0) state_d = DONE;
            R_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    cpu_rdata_d = ~ram_o;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Reload on every state entry, otherwise count down and park at zero
        if (state_d != state_q) cnt_d = phase_len(state_d);
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;

        ram_cs_d  = !(state_d inside {W_SETUP, W_PULSE, W_HOLD, R_ACCESS});
        ram_we_d  = (state_d != W_PULSE);
        busy_d    = (state_d != IDLE);
        cpu_ack_d = (state_d == DONE) && (own_d == OWN_CPU);
        ld_ack_d  = (state_d == DONE) && (own_d == OWN_LD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            own_q       <= OWN_CPU;
            wr_q        <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            cpu_rdata_q <= '0;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_q       <= own_d;
            wr_q        <= wr_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            cpu_rdata_q <= cpu_rdata_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_d     = ram_d_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sap_ram_seq.sv
// Bench for sap_ram_seq with two 189-type nibble chip models.
module tb_sap_ram_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_wr, ld_req;
    logic [3:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;
    logic       cpu_ack, ld_ack;
    logic [7:0] cpu_rdata;
    logic [3:0] ram_a;
    logic [7:0] ram_d, ram_o;
    logic       ram_cs, ram_we, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sap_ram_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .ram_a(ram_a), .ram_d(ram_d), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_o(ram_o), .busy(busy)
    );

    // Chip models: level write while cs and we are low, inverted outputs
    logic [3:0] lo_mem [16];
    logic [3:0] hi_mem [16];
    always @(negedge clk)
        if (!ram_cs && !ram_we) begin
            lo_mem[ram_a] <= ram_d[3:0];
            hi_mem[ram_a] <= ram_d[7:4];
        end
    assign ram_o = (!ram_cs && ram_we) ? ~{hi_mem[ram_a], lo_mem[ram_a]} : 8'hFF;

    // Scoreboard of expected acks
    typedef struct {
        bit         own_ld;
        logic [7:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] model [16];
    logic [7:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Ack monitor and pin invariants
    logic       prev_we_low = 1'b0;
    logic [3:0] prev_a;
    logic [7:0] prev_d;
    always @(negedge clk) begin : mon
        exp_t e;
        if (cpu_ack || ld_ack) begin
            checks++;
            if (cpu_ack && ld_ack) begin
                errors++;
                $display("FAIL sb_double_ack: cpu_ack=1 ld_ack=1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: ld_ack=%0b cpu_ack=%0b", ld_ack, cpu_ack);
            end else begin
                e = exp_q.pop_front();
                if (e.own_ld != ld_ack || cpu_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL sb_ack: ld_ack=%0b rdata=%0h expected ld=%0b rdata=%0h",
                             ld_ack, cpu_rdata, e.own_ld, e.rdata);
                end
            end
        end
        if (!ram_we) begin
            checks++;
            if (ram_cs) begin
                errors++;
                $display("FAIL inv_we_cs: ram_we=0 with ram_cs=%0b", ram_cs);
            end else if (prev_we_low && (ram_a !== prev_a || ram_d !== prev_d)) begin
                errors++;
                $display("FAIL inv_stable: a=%0h d=%0h was a=%0h d=%0h", ram_a, ram_d, prev_a, prev_d);
            end
        end
        prev_we_low = !ram_we;
        prev_a      = ram_a;
        prev_d      = ram_d;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    function automatic void push_exp(input bit is_ld, input bit wr, input logic [3:0] a,
                                     input logic [7:0] d);
        exp_t e;
        if (is_ld || wr) begin
            model[a] = d;
        end else begin
            last_rd = model[a];
        end
        e.own_ld = is_ld;
        e.rdata  = last_rd;
        exp_q.push_back(e);
    endfunction

    // One transaction; cycle c is the period after the c-th edge from grant
    task automatic txn(input bit is_ld, input bit wr, input logic [3:0] a, input logic [7:0] d,
                       output int lat, output logic [15:0] we_mask, output int cs_first);
        lat = -1; we_mask = '0; cs_first = -1;
        wait_idle();
        push_exp(is_ld, wr, a, d);
        if (is_ld) begin
            ld_req = 1'b1; ld_addr = a; ld_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        end
        @(posedge clk);
        #1;
        ld_req = 1'b0; cpu_req = 1'b0;
        ld_addr = 4'hx; cpu_addr = 4'hx; ld_wdata = 8'hxx; cpu_wdata = 8'hxx;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (c < 16 && !ram_we) we_mask[c] = 1'b1;
            if (!ram_cs && cs_first < 0) cs_first = c;
            if (ld_ack || cpu_ack) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        bit          is_ld;
        bit          wr;
        logic [3:0]  a;
        logic [7:0]  d;
        int          lat;
        logic [15:0] we_mask;
        logic [7:0]  rd;
    } vec_t;
    vec_t vt [4];

    initial begin
        int          lat, csf, ld_c, cpu_c;
        logic [15:0] wm;

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        last_rd = 8'h00;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_cs", ram_cs, 1);
        chk("rst_we", ram_we, 1);
        chk("rst_a", ram_a, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_acks", {cpu_ack, ld_ack}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Loader write then CPU read, plus a CPU write and read-back
        vt[0] = '{1'b1, 1'b1, 4'h3, 8'hA5, 5, 16'h000C, 8'h00};
        vt[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 3, 16'h0000, 8'hA5};
        vt[2] = '{1'b0, 1'b1, 4'hC, 8'h3E, 5, 16'h000C, 8'hA5};
        vt[3] = '{1'b0, 1'b0, 4'hC, 8'h00, 3, 16'h0000, 8'h3E};
        for (int i = 0; i < 4; i++) begin
            txn(vt[i].is_ld, vt[i].wr, vt[i].a, vt[i].d, lat, wm, csf);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_we_cycles", i), wm, vt[i].we_mask);
            chk($sformatf("vec%0d_cs_fall", i), csf, 1);
            chk($sformatf("vec%0d_rdata", i), cpu_rdata, vt[i].rd);
            if (vt[i].wr) chk($sformatf("vec%0d_chip", i), {hi_mem[vt[i].a], lo_mem[vt[i].a]}, vt[i].d);
        end

        // Simultaneous requests: loader write to 3 first, then CPU read of 3
        wait_idle();
        push_exp(1'b1, 1'b1, 4'h3, 8'h3C);
        push_exp(1'b0, 1'b0, 4'h3, 8'h00);
        ld_req = 1'b1; ld_addr = 4'h3; ld_wdata = 8'h3C;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h3;
        @(posedge clk);
        #1 ld_req = 1'b0;
        ld_c = -1; cpu_c = -1;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (ld_ack && ld_c < 0) ld_c = c;
            if (cpu_ack && cpu_c < 0) cpu_c = c;
            if (c == 6) chk("sim_idle_gap_cs", ram_cs, 1);
            if (c == 7) begin
                chk("sim_cpu_grant_cs", ram_cs, 0);
                cpu_req = 1'b0;
            end
        end
        chk("sim_ld_ack_cycle", ld_c, 5);
        chk("sim_cpu_ack_cycle", cpu_c, 9);
        chk("sim_rdata", cpu_rdata, 8'h3C);

        // Fill all addresses, read them back, then F -> 0
        for (int i = 0; i < 16; i++) txn(1'b1, 1'b1, 4'(i), 8'(i * 8'h11), lat, wm, csf);
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 1'b0, 4'(i), 8'h00, lat, wm, csf);
            chk($sformatf("fill_rd%0d", i), cpu_rdata, 8'(i * 8'h11));
        end
        txn(1'b0, 1'b0, 4'hF, 8'h00, lat, wm, csf);
        chk("wrap_rdF", cpu_rdata, 8'hFF);
        txn(1'b0, 1'b0, 4'h0, 8'h00, lat, wm, csf);
        chk("wrap_rd0", cpu_rdata, 8'h00);

        // Random stream, sequential requesters with random gaps
        for (int i = 0; i < 40; i++) begin
            bit         il, w;
            logic [3:0] a;
            logic [7:0] d;
            int         el;
            il = 1'($urandom_range(0, 1));
            w  = il ? 1'b1 : 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            el = w ? 5 : 3;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(il, w, a, d, lat, wm, csf);
            chk($sformatf("rnd%0d_latency", i), lat, el);
        end

        // Reset during the write pulse
        wait_idle();
        ld_req = 1'b1; ld_addr = 4'h7; ld_wdata = 8'hEE;
        @(posedge clk);
        #1 ld_req = 1'b0;
        for (int n = 0; n < 10 && ram_we; n++) @(negedge clk);
        chk("rst_mid_saw_pulse", ram_we, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_we", ram_we, 1);
        chk("rst_mid_cs", ram_cs, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ack", {cpu_ack, ld_ack}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 8'h00;
        repeat (4) @(negedge clk);
        txn(1'b0, 1'b1, 4'h9, 8'h77, lat, wm, csf);
        chk("post_rst_wr_latency", lat, 5);
        txn(1'b0, 1'b0, 4'h9, 8'h00, lat, wm, csf);
        chk("post_rst_rd", cpu_rdata, 8'h77);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
